spectro_bank_writer: RTL and testbench
======================================

// Module: spectro_bank_writer
// PURPOSE
//  Acquisition-side ping-pong writer for the two 200-entry spectrogram banks. Writes one frame per
//  frame_valid during an acoustic event (AE) and alternates banks. Produces the bank-full /
//  memorization-complete handshake consumed by the readout FSM, which reads the opposite bank.
// PARAMETERS
//  DATA_W      16   width of one spectrogram frame word written to memory
//  BANK_DEPTH  200  entries per bank (address 0..BANK_DEPTH-1, must be <=255)
//  FULL_HOLD   4    cycles bankN_full stays high (readout FSM needs >=2)
// PORTS
//  clk                     in   1       system clock
//  reset                   in   1       asynchronous, active-high
//  event_active            in   1       level, high while an AE is in progress
//  frame_valid             in   1       1-cycle strobe, frame_data valid
//  frame_data              in   DATA_W  spectrogram frame word
//  rd_busy                 in   1       readout sending a bank (readout sending_data)
//  rd_bank                 in   1       bank currently read (readout addr_out[8])
//  mem_we                  out  1       memory write enable
//  mem_waddr               out  9       {bank, index}
//  mem_wdata               out  DATA_W  registered copy of frame_data
//  bank0_full, bank1_full  out  1       bank filled by a long AE, held FULL_HOLD cycles
//  memorization_completed  out  1       1-cycle pulse, AE ended
//  idx_final               out  8       entries written in the last (partial) bank, 1..BANK_DEPTH
//  overflow                out  1       sticky, frame dropped because target bank was busy
// BEHAVIOUR
//  Reset: all outputs 0; write bank = 0, write index = 0, state IDLE.
//  Accepted frame = frame_valid && event_active in the same cycle; a frame coinciding with
//   event_active low is ignored. Write latency 1 cycle: mem_we/mem_waddr/mem_wdata registered.
//  FSM states:
//   IDLE:     index=0. event_active rising (vs. registered copy) -> WRITE.
//   WRITE:    each accepted frame writes {bank,index}, index++. Accepted frame with index==BANK_DEPTH
//             -> bank switch: current bank's full flag starts, bank toggles, frame written at index 0
//             of new bank, index=1. Bank full is therefore declared lazily, on the first write into
//             the next bank; an AE ending exactly at 200 entries takes the completion path with
//             idx_final=200 and no full flag.
//             event_active low: index==0 (no frame ever written) -> IDLE, no pulse, bank kept;
//             else idx_final<=index -> COMPLETE.
//   COMPLETE: one cycle. memorization_completed=1; idx_final already stable one cycle earlier
//             (readout latches it on the pulse's rising edge); bank toggles; -> IDLE.
//  idx_final holds its value until the next completion.
//  Every readout transaction toggles its read bank, so the write bank toggles on every bank switch
//   and every completion; the two stay in lock-step.
//  Full flag: bankN_full high for exactly FULL_HOLD cycles starting the cycle after the switch
//   write; a new switch during hold of the other bank is independent.
//  Busy target: when a switch (or an AE start) targets bank B while rd_busy && rd_bank==B, frames
//   are dropped (no mem_we, index stays), overflow<=1, until rd_busy falls; then writing resumes.
//  overflow clears only on reset. reset mid-AE aborts: no pulse, all state to reset values.
//  Index width 8 bits; index never exceeds BANK_DEPTH.
// STRUCTURE
//  spectro_pkg.vh: BANK_DEPTH, ADDR_W=9, IDX_W=8, state encodings (IDLE, WRITE, COMPLETE), shared
//   with readout FSM.
//  Sub-module spectro_hold_stretch: pulse -> FULL_HOLD-cycle level counter, instanced per bank.
// TESTING
//  AE of 50 frames -> 50 writes bank0 idx 0..49, pulse with idx_final=50, next AE writes bank1.
//  AE of 250 frames -> bank0_full high 4 cycles after write 201 ({1,0}), pulse idx_final=50.
//  AE of exactly 200 frames -> no bank0_full, pulse with idx_final=200.
//  frame_valid same cycle event_active falls -> frame not written, idx_final excludes it.
//  Switch while rd_busy=1,rd_bank=1 -> no mem_we, overflow=1; writes resume at index 0 after release.
//  reset asserted at write 120 -> outputs 0 immediately, no pulse, next AE starts bank0 idx 0.

Source files
------------

// File: rtl/spectro_bank_writer_pkg.sv
// spectro_bank_writer_pkg: shared bank geometry and writer state encodings
package spectro_bank_writer_pkg;
   localparam int BANK_DEPTH_DEF = 200;
   localparam int ADDR_W = 9;
   localparam int IDX_W = 8;
   typedef enum logic [1:0] {IDLE, WRITE, COMPLETE} wr_state_t;
endpackage

// File: rtl/spectro_bank_writer_hold_stretch.sv
// spectro_bank_writer_hold_stretch: turns a 1-cycle pulse into a HOLD-cycle level
module spectro_bank_writer_hold_stretch #(
   parameter int HOLD = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic pulse,
   output logic level
);
   localparam int CW = $clog2(HOLD + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else cnt <= pulse ? CW'(HOLD) : (cnt != '0 ? cnt - CW'(1) : cnt);
   assign level = cnt != '0;
endmodule

// File: rtl/spectro_bank_writer.sv
// spectro_bank_writer: ping-pong frame writer for the two spectrogram banks
module spectro_bank_writer
   import spectro_bank_writer_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int BANK_DEPTH = BANK_DEPTH_DEF,
   parameter int FULL_HOLD = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              event_active,
   input  logic              frame_valid,
   input  logic [DATA_W-1:0] frame_data,
   input  logic              rd_busy,
   input  logic              rd_bank,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              bank0_full,
   output logic              bank1_full,
   output logic              memorization_completed,
   output logic [IDX_W-1:0]  idx_final,
   output logic              overflow
);
   wr_state_t state;
   logic [IDX_W-1:0] idx, idx_w;
   logic bank, ev_q, sw, tgt_bank, blocked;
   logic [1:0] full_pulse;
   always_comb begin
      sw = idx == IDX_W'(BANK_DEPTH);
      tgt_bank = sw ? ~bank : bank;
      idx_w = sw ? '0 : idx;
      blocked = rd_busy && rd_bank == tgt_bank;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         idx <= '0;
         bank <= 1'b0;
         ev_q <= 1'b0;
         full_pulse <= '0;
         mem_we <= 1'b0;
         mem_waddr <= '0;
         mem_wdata <= '0;
         memorization_completed <= 1'b0;
         idx_final <= '0;
         overflow <= 1'b0;
      end else begin
         ev_q <= event_active;
         mem_we <= 1'b0;
         full_pulse <= '0;
         memorization_completed <= 1'b0;
         case (state)
            IDLE: begin
               idx <= '0;
               if (event_active && !ev_q) state <= WRITE;
            end
            WRITE:
               if (!event_active) begin
                  if (idx == '0) state <= IDLE;
                  else begin
                     idx_final <= idx;
                     state <= COMPLETE;
                  end
               end else if (frame_valid) begin
                  // a frame aimed at the bank being read out is dropped, index held
                  if (blocked) overflow <= 1'b1;
                  else begin
                     mem_we <= 1'b1;
                     mem_waddr <= {tgt_bank, idx_w};
                     mem_wdata <= frame_data;
                     idx <= idx_w + IDX_W'(1);
                     bank <= tgt_bank;
                     full_pulse <= {sw & bank, sw & ~bank};
                  end
               end
            COMPLETE: begin
               memorization_completed <= 1'b1;
               bank <= ~bank;
               idx <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   spectro_bank_writer_hold_stretch #(.HOLD(FULL_HOLD)) u_full0 (
      .clk(clk), .reset(reset), .pulse(full_pulse[0]), .level(bank0_full)
   );
   spectro_bank_writer_hold_stretch #(.HOLD(FULL_HOLD)) u_full1 (
      .clk(clk), .reset(reset), .pulse(full_pulse[1]), .level(bank1_full)
   );
endmodule

// File: tb/tb_spectro_bank_writer.sv
// tb_spectro_bank_writer: directed checks of the ping-pong bank writer
module tb_spectro_bank_writer;
   logic clk, reset, event_active, frame_valid, rd_busy, rd_bank;
   logic [15:0] frame_data, mem_wdata;
   logic mem_we, bank0_full, bank1_full, memorization_completed, overflow;
   logic [8:0] mem_waddr;
   logic [7:0] idx_final;
   int n_cmp = 0, n_bad = 0;

   spectro_bank_writer dut (
      .clk(clk), .reset(reset), .event_active(event_active), .frame_valid(frame_valid),
      .frame_data(frame_data), .rd_busy(rd_busy), .rd_bank(rd_bank), .mem_we(mem_we),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .bank0_full(bank0_full),
      .bank1_full(bank1_full), .memorization_completed(memorization_completed),
      .idx_final(idx_final), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_frame(input logic [15:0] d);
      frame_valid = 1'b1;
      frame_data = d;
      tick();
      frame_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      n_cmp++;
      if ({mem_we, mem_waddr, mem_wdata, bank0_full, bank1_full, memorization_completed, idx_final, overflow} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got we=%b addr=%h data=%h f0=%b f1=%b mc=%b idx=%0d ov=%b expected all 0",
                  mem_we, mem_waddr, mem_wdata, bank0_full, bank1_full, memorization_completed, idx_final, overflow);
      end
      reset = 1'b0;
      tick();
      n_cmp++;
      if ({mem_we, memorization_completed, overflow} !== 3'b000) begin
         n_bad++;
         $display("FAIL reset_release: got we=%b mc=%b ov=%b expected 0 0 0", mem_we, memorization_completed, overflow);
      end
   endtask

   task automatic test_short_ae;
      event_active = 1'b1;
      tick();
      for (int i = 0; i < 50; i++) begin
         drive_frame(16'h1000 + 16'(i));
         n_cmp++;
         if (mem_we !== 1'b1 || mem_waddr !== {1'b0, 8'(i)} || mem_wdata !== 16'h1000 + 16'(i)) begin
            n_bad++;
            $display("FAIL short_write[%0d]: got we=%b addr=%h data=%h expected 1 %h %h",
                     i, mem_we, mem_waddr, mem_wdata, {1'b0, 8'(i)}, 16'h1000 + 16'(i));
         end
      end
      event_active = 1'b0;
      tick();
      n_cmp++;
      if (idx_final !== 8'd50 || memorization_completed !== 1'b0) begin
         n_bad++;
         $display("FAIL short_idx_final: got idx=%0d mc=%b expected 50 0", idx_final, memorization_completed);
      end
      tick();
      n_cmp++;
      if (memorization_completed !== 1'b1) begin
         n_bad++;
         $display("FAIL short_pulse: got mc=%b expected 1", memorization_completed);
      end
      tick();
      n_cmp++;
      if (memorization_completed !== 1'b0) begin
         n_bad++;
         $display("FAIL short_pulse_width: got mc=%b expected 0", memorization_completed);
      end
      event_active = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         drive_frame(16'h2000 + 16'(i));
         n_cmp++;
         if (mem_we !== 1'b1 || mem_waddr !== {1'b1, 8'(i)}) begin
            n_bad++;
            $display("FAIL next_ae_bank1[%0d]: got we=%b addr=%h expected 1 %h", i, mem_we, mem_waddr, {1'b1, 8'(i)});
         end
      end
      event_active = 1'b0;
      tick();
      n_cmp++;
      if (idx_final !== 8'd3) begin
         n_bad++;
         $display("FAIL next_ae_idx_final: got %0d expected 3", idx_final);
      end
      tick();
      tick();
   endtask

   task automatic test_long_ae;
      event_active = 1'b1;
      tick();
      for (int i = 0; i < 250; i++) begin
         logic [8:0] ea;
         logic ef;
         ea = i < 200 ? {1'b0, 8'(i)} : {1'b1, 8'(i - 200)};
         ef = i >= 201 && i <= 204;
         drive_frame(16'h3000 + 16'(i));
         n_cmp++;
         if (mem_we !== 1'b1 || mem_waddr !== ea || bank0_full !== ef || bank1_full !== 1'b0) begin
            n_bad++;
            $display("FAIL long_write[%0d]: got we=%b addr=%h f0=%b f1=%b expected 1 %h %b 0",
                     i, mem_we, mem_waddr, bank0_full, bank1_full, ea, ef);
         end
      end
      event_active = 1'b0;
      tick();
      n_cmp++;
      if (idx_final !== 8'd50) begin
         n_bad++;
         $display("FAIL long_idx_final: got %0d expected 50", idx_final);
      end
      tick();
      n_cmp++;
      if (memorization_completed !== 1'b1) begin
         n_bad++;
         $display("FAIL long_pulse: got mc=%b expected 1", memorization_completed);
      end
      tick();
   endtask

   task automatic test_exact_200;
      event_active = 1'b1;
      tick();
      for (int i = 0; i < 200; i++) begin
         drive_frame(16'h4000 + 16'(i));
         n_cmp++;
         if (mem_we !== 1'b1 || mem_waddr !== {1'b0, 8'(i)} || bank0_full !== 1'b0) begin
            n_bad++;
            $display("FAIL exact_write[%0d]: got we=%b addr=%h f0=%b expected 1 %h 0", i, mem_we, mem_waddr, bank0_full, {1'b0, 8'(i)});
         end
      end
      event_active = 1'b0;
      tick();
      n_cmp++;
      if (idx_final !== 8'd200 || bank0_full !== 1'b0) begin
         n_bad++;
         $display("FAIL exact_idx_final: got idx=%0d f0=%b expected 200 0", idx_final, bank0_full);
      end
      tick();
      n_cmp++;
      if (memorization_completed !== 1'b1 || bank0_full !== 1'b0) begin
         n_bad++;
         $display("FAIL exact_pulse: got mc=%b f0=%b expected 1 0", memorization_completed, bank0_full);
      end
      tick();
   endtask

   task automatic test_drop_on_fall;
      event_active = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         drive_frame(16'h5000 + 16'(i));
         n_cmp++;
         if (mem_we !== 1'b1 || mem_waddr !== {1'b1, 8'(i)}) begin
            n_bad++;
            $display("FAIL fall_write[%0d]: got we=%b addr=%h expected 1 %h", i, mem_we, mem_waddr, {1'b1, 8'(i)});
         end
      end
      event_active = 1'b0;
      drive_frame(16'h5FFF);
      n_cmp++;
      if (mem_we !== 1'b0 || idx_final !== 8'd5) begin
         n_bad++;
         $display("FAIL fall_frame_ignored: got we=%b idx=%0d expected 0 5", mem_we, idx_final);
      end
      tick();
      n_cmp++;
      if (memorization_completed !== 1'b1) begin
         n_bad++;
         $display("FAIL fall_pulse: got mc=%b expected 1", memorization_completed);
      end
      tick();
   endtask

   task automatic test_busy_switch;
      event_active = 1'b1;
      tick();
      for (int i = 0; i < 200; i++) drive_frame(16'h6000 + 16'(i));
      n_cmp++;
      if (mem_waddr !== 9'h0C7 || overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL busy_prefill: got addr=%h ov=%b expected 0c7 0", mem_waddr, overflow);
      end
      rd_busy = 1'b1;
      rd_bank = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_frame(16'h6100 + 16'(i));
         n_cmp++;
         if (mem_we !== 1'b0 || overflow !== 1'b1 || bank0_full !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_drop[%0d]: got we=%b ov=%b f0=%b expected 0 1 0", i, mem_we, overflow, bank0_full);
         end
      end
      rd_busy = 1'b0;
      drive_frame(16'h6200);
      n_cmp++;
      if (mem_we !== 1'b1 || mem_waddr !== 9'h100 || mem_wdata !== 16'h6200) begin
         n_bad++;
         $display("FAIL busy_resume: got we=%b addr=%h data=%h expected 1 100 6200", mem_we, mem_waddr, mem_wdata);
      end
      event_active = 1'b0;
      tick();
      n_cmp++;
      if (bank0_full !== 1'b1 || idx_final !== 8'd1 || overflow !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_after: got f0=%b idx=%0d ov=%b expected 1 1 1", bank0_full, idx_final, overflow);
      end
      tick();
      tick();
      rd_bank = 1'b0;
   endtask

   task automatic test_reset_mid;
      event_active = 1'b1;
      tick();
      drive_frame(16'h7000);
      drive_frame(16'h7001);
      event_active = 1'b0;
      tick();
      tick();
      tick();
      event_active = 1'b1;
      tick();
      for (int i = 0; i < 120; i++) drive_frame(16'h7100 + 16'(i));
      n_cmp++;
      if (mem_waddr !== {1'b1, 8'd119}) begin
         n_bad++;
         $display("FAIL reset_mid_prefill: got addr=%h expected 177", mem_waddr);
      end
      frame_valid = 1'b1;
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({mem_we, mem_waddr, mem_wdata, idx_final, overflow, memorization_completed} !== '0) begin
         n_bad++;
         $display("FAIL reset_mid_async: got we=%b addr=%h data=%h idx=%0d ov=%b mc=%b expected all 0",
                  mem_we, mem_waddr, mem_wdata, idx_final, overflow, memorization_completed);
      end
      frame_valid = 1'b0;
      event_active = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) reset = 1'b0;
         n_cmp++;
         if (memorization_completed !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_no_pulse[%0d]: got mc=%b expected 0", i, memorization_completed);
         end
      end
      tick();
      event_active = 1'b1;
      tick();
      drive_frame(16'h7ABC);
      n_cmp++;
      if (mem_we !== 1'b1 || mem_waddr !== 9'h000 || mem_wdata !== 16'h7ABC) begin
         n_bad++;
         $display("FAIL reset_mid_restart: got we=%b addr=%h data=%h expected 1 000 7abc", mem_we, mem_waddr, mem_wdata);
      end
      event_active = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (memorization_completed !== 1'b1 || idx_final !== 8'd1) begin
         n_bad++;
         $display("FAIL reset_mid_complete: got mc=%b idx=%0d expected 1 1", memorization_completed, idx_final);
      end
   endtask

   initial begin
      reset = 1'b1;
      event_active = 1'b0;
      frame_valid = 1'b0;
      frame_data = '0;
      rd_busy = 1'b0;
      rd_bank = 1'b0;
      test_reset();
      test_short_ae();
      test_long_ae();
      test_exact_200();
      test_drop_on_fall();
      test_busy_switch();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
